// File: rtl/mem_arbiter_if.sv
// Bundled requester and memory-side signals of the two-port memory arbiter.
// The arbiter connects through the slave modport; the master modport is for the environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              p0_enable_i;
  logic              p0_write_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_data_i;
  logic [DATA_W-1:0] p0_data_o;
  logic              p0_ack_o;

  logic              p1_enable_i;
  logic              p1_write_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic [DATA_W-1:0] p1_data_o;
  logic              p1_ack_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p0_data_o, p0_ack_o,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_data_o, p1_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p0_data_o, p0_ack_o,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_data_o, p1_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between two requesters,
// with a watchdog that aborts a transaction the memory never acknowledges.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_arbiter_if.slave    bus,
  output logic [1:0]      grant_o,
  output logic            err_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             win_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;

  logic any_req, pick1, tmo;
  logic start, finish, abort;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY: begin
        if (bus.mem_ack_i) state_d = DONE;
        else if (tmo)      state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration and transaction control; on a tie the port that did not win last goes next
  always_comb begin
    any_req = bus.p0_enable_i | bus.p1_enable_i;
    pick1   = bus.p1_enable_i & (~bus.p0_enable_i | ~last_q);
    tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));
    start   = (state_q == IDLE) & any_req;
    finish  = (state_q == BUSY) & bus.mem_ack_i;
    abort   = (state_q == BUSY) & ~bus.mem_ack_i & tmo;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.mem_enable_o <= 1'b0;
      bus.mem_write_o  <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_data_o   <= '0;
      bus.p0_data_o    <= '0;
      bus.p1_data_o    <= '0;
      bus.p0_ack_o     <= 1'b0;
      bus.p1_ack_o     <= 1'b0;
      grant_o          <= '0;
      err_o            <= 1'b0;
      win_q            <= 1'b0;
      last_q           <= 1'b1;
      cnt_q            <= '0;
    end else begin
      if (start) begin
        bus.mem_enable_o <= 1'b1;
        bus.mem_write_o  <= pick1 ? bus.p1_write_i : bus.p0_write_i;
        bus.mem_addr_o   <= pick1 ? bus.p1_addr_i  : bus.p0_addr_i;
        bus.mem_data_o   <= pick1 ? bus.p1_data_i  : bus.p0_data_i;
        grant_o          <= pick1 ? 2'b10 : 2'b01;
        win_q            <= pick1;
        cnt_q            <= '0;
      end

      if (finish) begin
        bus.mem_enable_o <= 1'b0;
        bus.p0_ack_o     <= ~win_q;
        bus.p1_ack_o     <= win_q;
        last_q           <= win_q;
        if (!bus.mem_write_o) begin
          if (win_q) bus.p1_data_o <= bus.mem_data_i;
          else       bus.p0_data_o <= bus.mem_data_i;
        end
      end else if (abort) begin
        bus.mem_enable_o <= 1'b0;
        err_o            <= 1'b1;
        grant_o          <= '0;
        last_q           <= win_q;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == DONE) begin
        bus.p0_ack_o <= 1'b0;
        bus.p1_ack_o <= 1'b0;
        grant_o      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance with the default watchdog
// and a second with TIMEOUT=8 for the abort scenario.
module tb_mem_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] grant_a, grant_b;
  logic       err_a, err_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [255:0] D_AA = {32{8'hAA}};
  localparam logic [255:0] D_55 = {32{8'h55}};
  localparam logic [255:0] D0   = {8{32'h0000_1111}};
  localparam logic [255:0] D1   = {8{32'h2222_0000}};
  localparam logic [255:0] D2   = {8{32'h3333_3333}};
  localparam logic [255:0] D3   = {8{32'h4444_5555}};

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus_b ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(64)) u_dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus_a.slave),
    .grant_o(grant_a),
    .err_o  (err_a)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(8)) u_dut_to (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus_b.slave),
    .grant_o(grant_b),
    .err_o  (err_b)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_a.p0_enable_i = 0; bus_a.p0_write_i = 0; bus_a.p0_addr_i = '0; bus_a.p0_data_i = '0;
    bus_a.p1_enable_i = 0; bus_a.p1_write_i = 0; bus_a.p1_addr_i = '0; bus_a.p1_data_i = '0;
    bus_a.mem_ack_i = 0;   bus_a.mem_data_i = '0;
    bus_b.p0_enable_i = 0; bus_b.p0_write_i = 0; bus_b.p0_addr_i = '0; bus_b.p0_data_i = '0;
    bus_b.p1_enable_i = 0; bus_b.p1_write_i = 0; bus_b.p1_addr_i = '0; bus_b.p1_data_i = '0;
    bus_b.mem_ack_i = 0;   bus_b.mem_data_i = '0;

    // Reset state
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mem_en",  bus_a.mem_enable_o, 1'b0);
    chk("rst_grant",   grant_a, 2'b00);
    chk("rst_err",     err_a, 1'b0);
    tick(); tick();
    chk("rst_p0_data", bus_a.p0_data_o, '0);
    chk("rst_p1_ack",  bus_a.p1_ack_o, 1'b0);
    rst_i = 1'b1;
    tick();

    // Single read, port 1, memory acks in its 10th busy cycle
    bus_a.p1_enable_i = 1; bus_a.p1_write_i = 0; bus_a.p1_addr_i = 32'h0000_0400;
    tick();
    chk("rd_mem_en",   bus_a.mem_enable_o, 1'b1);
    chk("rd_grant",    grant_a, 2'b10);
    chk("rd_addr",     bus_a.mem_addr_o, 32'h0000_0400);
    chk("rd_write",    bus_a.mem_write_o, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("rd_busy_en", bus_a.mem_enable_o, 1'b1);
      chk("rd_busy_ack", bus_a.p1_ack_o, 1'b0);
    end
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D_AA;
    tick();
    bus_a.mem_ack_i = 0; bus_a.p1_enable_i = 0; bus_a.mem_data_i = '0;
    chk("rd_ack",      bus_a.p1_ack_o, 1'b1);
    chk("rd_data",     bus_a.p1_data_o, D_AA);
    chk("rd_done_en",  bus_a.mem_enable_o, 1'b0);
    chk("rd_done_gnt", grant_a, 2'b10);
    chk("rd_p0_ack",   bus_a.p0_ack_o, 1'b0);
    tick();
    chk("rd_ack_clr",  bus_a.p1_ack_o, 1'b0);
    chk("rd_gnt_clr",  grant_a, 2'b00);
    tick();
    chk("rd_data_hold", bus_a.p1_data_o, D_AA);
    chk("rd_idle_en",  bus_a.mem_enable_o, 1'b0);

    // Simultaneous requests from reset: port 0 first, then port 1
    rst_i = 1'b0; tick(); rst_i = 1'b1; tick();
    bus_a.p0_enable_i = 1; bus_a.p0_write_i = 0; bus_a.p0_addr_i = 32'h0000_0100;
    bus_a.p1_enable_i = 1; bus_a.p1_write_i = 0; bus_a.p1_addr_i = 32'h0000_0200;
    tick();
    chk("tie1_grant",  grant_a, 2'b01);
    chk("tie1_addr",   bus_a.mem_addr_o, 32'h0000_0100);
    tick();
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D0;
    tick();
    bus_a.mem_ack_i = 0; bus_a.p0_enable_i = 0;
    chk("tie1_ack",    bus_a.p0_ack_o, 1'b1);
    chk("tie1_data",   bus_a.p0_data_o, D0);
    chk("tie1_p1ack",  bus_a.p1_ack_o, 1'b0);
    chk("tie1_done_en", bus_a.mem_enable_o, 1'b0);
    tick();
    chk("tie1_idle_en", bus_a.mem_enable_o, 1'b0);
    chk("tie1_idle_gnt", grant_a, 2'b00);
    tick();
    chk("tie2_en",     bus_a.mem_enable_o, 1'b1);
    chk("tie2_grant",  grant_a, 2'b10);
    chk("tie2_addr",   bus_a.mem_addr_o, 32'h0000_0200);
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D1;
    tick();
    bus_a.mem_ack_i = 0; bus_a.p1_enable_i = 0;
    chk("tie2_ack",    bus_a.p1_ack_o, 1'b1);
    chk("tie2_data",   bus_a.p1_data_o, D1);
    chk("tie2_p0hold", bus_a.p0_data_o, D0);
    tick();
    // Third tie alternates back to port 0
    bus_a.p0_enable_i = 1; bus_a.p1_enable_i = 1;
    tick();
    chk("tie3_grant",  grant_a, 2'b01);
    chk("tie3_addr",   bus_a.mem_addr_o, 32'h0000_0100);
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D2;
    tick();
    bus_a.mem_ack_i = 0; bus_a.p0_enable_i = 0; bus_a.p1_enable_i = 0;
    chk("tie3_ack",    bus_a.p0_ack_o, 1'b1);
    chk("tie3_data",   bus_a.p0_data_o, D2);
    tick();

    // Write from port 0; inputs changed mid-transaction must not leak through
    bus_a.p0_enable_i = 1; bus_a.p0_write_i = 1;
    bus_a.p0_addr_i = 32'h0000_0020; bus_a.p0_data_i = D_55;
    tick();
    chk("wr_write",    bus_a.mem_write_o, 1'b1);
    chk("wr_addr",     bus_a.mem_addr_o, 32'h0000_0020);
    chk("wr_data",     bus_a.mem_data_o, D_55);
    bus_a.p0_addr_i = 32'h0000_0FF0; bus_a.p0_data_i = D3; bus_a.p0_write_i = 0;
    tick();
    chk("wr_hold_addr", bus_a.mem_addr_o, 32'h0000_0020);
    chk("wr_hold_data", bus_a.mem_data_o, D_55);
    chk("wr_hold_wr",   bus_a.mem_write_o, 1'b1);
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D3;
    tick();
    bus_a.mem_ack_i = 0; bus_a.p0_enable_i = 0; bus_a.mem_data_i = '0;
    chk("wr_ack",      bus_a.p0_ack_o, 1'b1);
    chk("wr_p0_data",  bus_a.p0_data_o, D2);
    tick();
    chk("wr_ack_clr",  bus_a.p0_ack_o, 1'b0);

    // Stray memory ack while idle
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D3;
    tick(); tick();
    chk("stray_en",    bus_a.mem_enable_o, 1'b0);
    chk("stray_gnt",   grant_a, 2'b00);
    chk("stray_ack0",  bus_a.p0_ack_o, 1'b0);
    chk("stray_ack1",  bus_a.p1_ack_o, 1'b0);
    chk("stray_data",  bus_a.p1_data_o, D1);
    bus_a.mem_ack_i = 0; bus_a.mem_data_i = '0;
    tick();

    // Reset during BUSY aborts silently; next tie goes to port 0
    bus_a.p1_enable_i = 1; bus_a.p1_write_i = 0; bus_a.p1_addr_i = 32'h0000_0800;
    tick();
    chk("mrst_busy_gnt", grant_a, 2'b10);
    tick();
    #2 rst_i = 1'b0;
    #1;
    chk("mrst_en",     bus_a.mem_enable_o, 1'b0);
    chk("mrst_gnt",    grant_a, 2'b00);
    chk("mrst_addr",   bus_a.mem_addr_o, '0);
    chk("mrst_p1data", bus_a.p1_data_o, '0);
    chk("mrst_p0data", bus_a.p0_data_o, '0);
    bus_a.p1_enable_i = 0;
    tick();
    rst_i = 1'b1;
    tick();
    chk("mrst_noack",  bus_a.p1_ack_o, 1'b0);
    bus_a.p0_enable_i = 1; bus_a.p0_write_i = 0; bus_a.p1_enable_i = 1;
    tick();
    chk("mrst_tie_gnt", grant_a, 2'b01);
    bus_a.mem_ack_i = 1; bus_a.mem_data_i = D3;
    tick();
    bus_a.mem_ack_i = 0; bus_a.p0_enable_i = 0; bus_a.p1_enable_i = 0;
    chk("mrst_tie_ack", bus_a.p0_ack_o, 1'b1);
    tick();
    chk("a_err_clear", err_a, 1'b0);

    // Watchdog: TIMEOUT=8 instance, memory never acks
    bus_b.p0_enable_i = 1; bus_b.p0_write_i = 0; bus_b.p0_addr_i = 32'h0000_0040;
    tick();
    chk("to_en0",      bus_b.mem_enable_o, 1'b1);
    chk("to_gnt",      grant_b, 2'b01);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_busy_en", bus_b.mem_enable_o, 1'b1);
      chk("to_busy_err", err_b, 1'b0);
    end
    tick();
    bus_b.p0_enable_i = 0;
    chk("to_drop_en",  bus_b.mem_enable_o, 1'b0);
    chk("to_err",      err_b, 1'b1);
    chk("to_gnt_clr",  grant_b, 2'b00);
    chk("to_noack0",   bus_b.p0_ack_o, 1'b0);
    chk("to_noack1",   bus_b.p1_ack_o, 1'b0);
    tick();
    chk("to_err_hold", err_b, 1'b1);
    chk("to_idle_en",  bus_b.mem_enable_o, 1'b0);
    chk("to_noack_b",  bus_b.p0_ack_o, 1'b0);
    // Service continues after the error
    bus_b.p1_enable_i = 1; bus_b.p1_write_i = 0; bus_b.p1_addr_i = 32'h0000_0080;
    tick();
    chk("to_next_gnt", grant_b, 2'b10);
    chk("to_next_addr", bus_b.mem_addr_o, 32'h0000_0080);
    tick();
    bus_b.mem_ack_i = 1; bus_b.mem_data_i = D3;
    tick();
    bus_b.mem_ack_i = 0; bus_b.p1_enable_i = 0;
    chk("to_next_ack", bus_b.p1_ack_o, 1'b1);
    chk("to_next_data", bus_b.p1_data_o, D3);
    chk("to_err_sticky", err_b, 1'b1);
    tick();
    chk("to_err_final", err_b, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256-bit off-chip data-memory port between the instruction-cache refill path (port 0) and `dcache_top` (port 1). It sits between the CPU's cache controllers and the `Data_Memory` model: it grants one requester at a time, holds the memory request stable until `mem_ack_i`, and returns the line and a one-cycle acknowledge to the winner. A watchdog flags a memory that never acknowledges.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 256, cache-line width
- `TIMEOUT`, 64, BUSY cycles without ack before abort (≥ 2)

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `p0_enable_i`, `p1_enable_i`  in  1  request valid; held high until the port's ack
- `p0_write_i`, `p1_write_i`  in  1  1 = line write, 0 = line read
- `p0_addr_i`, `p1_addr_i`  in  ADDR_W  line address
- `p0_data_i`, `p1_data_i`  in  DATA_W  write data
- `p0_data_o`, `p1_data_o`  out  DATA_W  last read line returned to that port
- `p0_ack_o`, `p1_ack_o`  out  1  one-cycle completion pulse
- `mem_enable_o`  out  1  memory request
- `mem_write_o`  out  1  memory write
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_data_o`  out  DATA_W  memory write data
- `mem_data_i`  in  DATA_W  memory read data, valid with ack
- `mem_ack_i`  in  1  memory completion
- `grant_o`  out  2  one-hot current owner, 00 when idle
- `err_o`  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if no enable, stay. If exactly one enable, that port wins. If both, winner = port not equal to `last_grant` (round-robin). On the decision edge: latch winner's write/addr/data into the `mem_*_o` registers, set `mem_enable_o`=1, `grant_o` one-hot, go BUSY.
- BUSY: `mem_*_o` held constant. The watchdog counter increments each cycle.
  - `mem_ack_i`=1: if the latched op is a read, capture `mem_data_i` into the winner's `pN_data_o`. Set the winner's `pN_ack_o`=1, `mem_enable_o`=0, `last_grant`=winner, go DONE.
  - Counter reaches TIMEOUT-1 without ack: `mem_enable_o`=0, `err_o`=1, `grant_o`=00, no ack to the port, `last_grant`=winner, go IDLE.
- DONE: exactly one cycle. `pN_ack_o` is high and enables are ignored. Next edge: clear ack and `grant_o`, go IDLE.
- Write acks leave `pN_data_o` unchanged. Each `pN_data_o` holds its value until the next read ack to that port.
- `mem_ack_i` outside BUSY is ignored.
- `err_o` clears only on reset. The arbiter keeps serving after an error.

## Timing
- Reset (asynchronous, immediate):
  - all outputs 0
  - state IDLE
  - watchdog counter 0
  - `last_grant`=1, so port 0 wins the first tie
- Request latency: enable high in cycle t (IDLE) -> `mem_enable_o` high in t+1.
- Completion: ack sampled in cycle a -> `pN_ack_o` and `pN_data_o` valid in a+1 (DONE) -> IDLE at a+2.
  - A pending request from the other port is granted at a+2 and is visible on `mem_enable_o` at a+3.
- Minimum spacing between two memory requests: 2 idle cycles of `mem_enable_o`.
- Requesters must drop enable the cycle after seeing ack. An enable still high in IDLE is treated as a new request.
- Inputs changing while BUSY have no effect on `mem_*_o`.
- Reset asserted mid-BUSY aborts the transaction silently; no ack is issued.

## Test plan
- **Single read.** Port 1 reads addr 0x0000_0400; memory acks after 10 cycles with data 0xAA..AA. Required: `mem_enable_o` high for 10 cycles, `p1_ack_o` exactly one cycle later, `p1_data_o`=0xAA..AA, `grant_o` 10 then 00.
- **Simultaneous requests.** Both ports request from reset. Required:
  - port 0 granted first
  - port 1 `mem_enable_o` rises 3 cycles after port 0's ack sample
  - a third tie goes to port 0 again (alternation)
- **Write.** Port 0 writes 0x55..55 to 0x0000_0020. Required: `mem_write_o`=1, `mem_data_o`=0x55..55 held through BUSY, `p0_ack_o` pulses, `p0_data_o` unchanged.
- **Timeout.** TIMEOUT=8; memory never acks. Required:
  - `mem_enable_o` drops after 8 BUSY cycles
  - `err_o`=1 and stays 1
  - no `pN_ack_o`
  - the next request is still served normally
- **Reset mid-transaction.** `rst_i` low during BUSY. Required: all outputs 0 immediately, no ack, and after release a tie is granted to port 0.
- **Stray ack.** `mem_ack_i` pulsed while IDLE. Required: no ack, no state change.
